// File: rtl/unidade_pc_pkg.sv
// Shared definitions for the fetch-stage PC unit: opcodes, instruction fields, FSM states.
package unidade_pc_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned TARGET_W = 26;

    localparam logic [OPCODE_W-1:0] OP_STOP = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'b000001;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_AND  = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_OR   = 6'b000110;
    localparam logic [OPCODE_W-1:0] OP_SLT  = 6'b000111;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_LI   = 6'b001001;
    localparam logic [OPCODE_W-1:0] OP_SW   = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_LW   = 6'b001011;
    localparam logic [OPCODE_W-1:0] OP_JR   = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_J    = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 6'b001110;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b001111;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 6'b010000;
    localparam logic [OPCODE_W-1:0] OP_BGT  = 6'b010001;
    localparam logic [OPCODE_W-1:0] OP_BLT  = 6'b010010;
    localparam logic [OPCODE_W-1:0] OP_BGE  = 6'b010011;
    localparam logic [OPCODE_W-1:0] OP_BLE  = 6'b010100;
    localparam logic [OPCODE_W-1:0] OP_MAX  = 6'b010111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Control-flow view of an instruction word.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [TARGET_W-1:0] target26;
    } instr_cf_t;

    function automatic logic is_branch(input logic [OPCODE_W-1:0] op);
        return (op >= OP_BEQ) && (op <= OP_BLE);
    endfunction

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/unidade_pc_calc_prox_pc.sv
// Combinational next-PC computation and legality checks for the current instruction.
module unidade_pc_calc_prox_pc
    import unidade_pc_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic [31:0] pc,
    input  logic [31:0] instrucao,
    input  logic        branch_cond,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc_c,
    output logic [31:0] pc_plus1_c,
    output logic        out_of_range_c,
    output logic        is_stop_c,
    output logic        is_illegal_c
);

    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

    instr_cf_t cf;

    assign cf         = instr_cf_t'(instrucao);
    assign pc_plus1_c = pc + 32'd1;

    // Target selection; all arithmetic wraps modulo 2^32.
    always_comb begin
        next_pc_c = pc_plus1_c;
        case (cf.opcode)
            OP_JR:        next_pc_c = rs_data;
            OP_J, OP_JAL: next_pc_c = 32'(cf.target26);
            default: begin
                if (is_branch(cf.opcode) && branch_cond) begin
                    next_pc_c = pc_plus1_c + sext_imm(cf.target26[IMM_W-1:0]);
                end
            end
        endcase
    end

    // A backward branch past 0 wraps to a huge value and is caught here too.
    assign out_of_range_c = (next_pc_c >= DEPTH);
    assign is_stop_c      = (instrucao == 32'h0);
    assign is_illegal_c   = (cf.opcode > OP_MAX);

endmodule

// File: rtl/unidade_pc.sv
// Program counter and run/halt/fault control for the single-cycle core's fetch stage.
module unidade_pc
    import unidade_pc_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic [31:0] instrucao,
    input  logic        branch_cond,
    input  logic [31:0] rs_data,
    output logic [31:0] endereco_pc,
    output logic [31:0] pc_plus1,
    output logic        running,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instr_count
);

    localparam logic [31:0] RESET_PC = 32'(RESET_ADDR);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] cnt_nxt;
    logic [31:0] next_pc_c;
    logic        out_of_range_c;
    logic        is_stop_c;
    logic        is_illegal_c;

    unidade_pc_calc_prox_pc #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_calc_prox_pc (
        .pc             (endereco_pc),
        .instrucao      (instrucao),
        .branch_cond    (branch_cond),
        .rs_data        (rs_data),
        .next_pc_c      (next_pc_c),
        .pc_plus1_c     (pc_plus1),
        .out_of_range_c (out_of_range_c),
        .is_stop_c      (is_stop_c),
        .is_illegal_c   (is_illegal_c)
    );

    // State, PC, counter and status flags; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            endereco_pc <= RESET_PC;
            instr_count <= 32'd0;
            running     <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            endereco_pc <= pc_nxt;
            instr_count <= cnt_nxt;
            running     <= (state_nxt == S_RUN);
            halted      <= (state_nxt == S_HALT);
            fault       <= (state_nxt == S_FAULT);
        end
    end

    // Next-state logic; stall freezes RUN ahead of every stop/fault check.
    always_comb begin
        state_nxt = state;
        pc_nxt    = endereco_pc;
        cnt_nxt   = instr_count;
        case (state)
            S_IDLE: begin
                pc_nxt = RESET_PC;
                if (start) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = 32'd0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (is_stop_c) begin
                        state_nxt = S_HALT;
                    end else if (is_illegal_c || out_of_range_c) begin
                        state_nxt = S_FAULT;
                    end else begin
                        pc_nxt  = next_pc_c;
                        cnt_nxt = instr_count + 32'd1;
                    end
                end
            end
            S_HALT, S_FAULT: begin
                if (start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = RESET_PC;
                    cnt_nxt   = 32'd0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pc_nxt    = RESET_PC;
            end
        endcase
    end

endmodule

// File: tb/tb_unidade_pc.sv
// Directed bench for unidade_pc: control flow, stall, stop/fault and a factorial program.
module tb_unidade_pc;

    localparam logic [5:0] T_ADD  = 6'b000001;
    localparam logic [5:0] T_MUL  = 6'b000011;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_LI   = 6'b001001;
    localparam logic [5:0] T_JR   = 6'b001100;
    localparam logic [5:0] T_J    = 6'b001101;
    localparam logic [5:0] T_JAL  = 6'b001110;
    localparam logic [5:0] T_BEQ  = 6'b001111;
    localparam logic [5:0] T_BLE  = 6'b010100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic [31:0] instrucao;
    logic        branch_cond;
    logic [31:0] rs_data;
    logic [31:0] endereco_pc;
    logic [31:0] pc_plus1;
    logic        running;
    logic        halted;
    logic        fault;
    logic [31:0] instr_count;

    logic        use_mem;
    logic [31:0] instr_drv;
    logic        bc_drv;
    logic [31:0] rs_drv;
    logic [31:0] mem [256];
    logic [31:0] regs [32];
    logic [31:0] mem_word;

    int n_tests = 0;
    int n_fail  = 0;

    unidade_pc #(
        .MEM_DEPTH  (256),
        .RESET_ADDR (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .instrucao   (instrucao),
        .branch_cond (branch_cond),
        .rs_data     (rs_data),
        .endereco_pc (endereco_pc),
        .pc_plus1    (pc_plus1),
        .running     (running),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    // Instruction source and register-file view: memory model or directed values.
    always_comb begin
        mem_word    = mem[endereco_pc[7:0]];
        instrucao   = instr_drv;
        branch_cond = bc_drv;
        rs_data     = rs_drv;
        if (use_mem) begin
            instrucao = mem_word;
            rs_data   = regs[mem_word[25:21]];
            branch_cond = 1'b0;
            if (mem_word[31:26] == T_BLE) begin
                branch_cond = ($signed(regs[mem_word[25:21]]) <= $signed(regs[mem_word[20:16]]));
            end
        end
    end

    // Register model: retires the presented instruction on each unstalled RUN edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) regs[r] <= 32'd0;
        end else if (use_mem && running && !stall) begin
            case (mem_word[31:26])
                T_LI:   regs[mem_word[20:16]] <= {{16{mem_word[15]}}, mem_word[15:0]};
                T_ADDI: regs[mem_word[20:16]] <= regs[mem_word[25:21]] + {{16{mem_word[15]}}, mem_word[15:0]};
                T_MUL:  regs[mem_word[15:11]] <= regs[mem_word[25:21]] * regs[mem_word[20:16]];
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] add_w;
        add_w = enc(T_ADD, 5'd1, 5'd2, 16'h1800);
        for (int a = 0; a < 256; a++) mem[a] = 32'h0;
        mem[0] = enc(T_LI, 5'd0, 5'd1, 16'd6);
        mem[1] = enc(T_LI, 5'd0, 5'd3, 16'd1);
        mem[2] = enc(T_LI, 5'd0, 5'd2, 16'd1);
        mem[3] = enc(T_BLE, 5'd1, 5'd3, 16'd3);
        mem[4] = enc(T_MUL, 5'd2, 5'd1, {5'd2, 11'd0});
        mem[5] = enc(T_ADDI, 5'd1, 5'd1, 16'hFFFF);
        mem[6] = enc_j(T_J, 26'd3);
        mem[7] = 32'h0;

        reset = 1'b1; start = 1'b0; stall = 1'b0; use_mem = 1'b0;
        instr_drv = add_w; bc_drv = 1'b0; rs_drv = 32'd0;
        step();
        chk("rst_pc", endereco_pc, 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);

        reset = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("start_running", 32'(running), 32'd1);
        chk("start_pc", endereco_pc, 32'd0);
        step(); chk("seq_pc1", endereco_pc, 32'd1);
        step(); chk("seq_pc2", endereco_pc, 32'd2);
        step(); chk("seq_pc3", endereco_pc, 32'd3);
        chk("seq_cnt3", instr_count, 32'd3);

        instr_drv = enc_j(T_J, 26'd2);
        step(); chk("j2_pc", endereco_pc, 32'd2);
        instr_drv = enc(T_BEQ, 5'd0, 5'd0, 16'hFFFE); bc_drv = 1'b1;
        #1 chk("beq_plus1", pc_plus1, 32'd3);
        step(); chk("beq_taken_pc", endereco_pc, 32'd1);
        chk("beq_taken_cnt", instr_count, 32'd5);
        instr_drv = add_w; bc_drv = 1'b0;
        step(); chk("add_pc2", endereco_pc, 32'd2);
        instr_drv = enc(T_BEQ, 5'd0, 5'd0, 16'hFFFE);
        step(); chk("beq_nt_pc", endereco_pc, 32'd3);

        instr_drv = enc_j(T_J, 26'd0);
        step(); chk("j0_pc", endereco_pc, 32'd0);
        instr_drv = enc_j(T_J, 26'd3);
        step(); chk("j3_pc", endereco_pc, 32'd3);
        instr_drv = enc_j(T_J, 26'd2);
        step();
        instr_drv = enc_j(T_JAL, 26'd6);
        #1 chk("jal_link", pc_plus1, 32'd3);
        step(); chk("jal_pc", endereco_pc, 32'd6);
        instr_drv = enc(T_JR, 5'd4, 5'd0, 16'd0); rs_drv = 32'd3;
        step(); chk("jr_pc", endereco_pc, 32'd3);
        chk("jr_cnt", instr_count, 32'd12);

        instr_drv = add_w; start = 1'b1;
        step(); start = 1'b0;
        chk("start_in_run_pc", endereco_pc, 32'd4);
        chk("start_in_run_cnt", instr_count, 32'd13);

        stall = 1'b1;
        repeat (3) step();
        chk("stall_pc", endereco_pc, 32'd4);
        chk("stall_cnt", instr_count, 32'd13);
        stall = 1'b0;
        step(); chk("resume_pc", endereco_pc, 32'd5);

        instr_drv = 32'h0; stall = 1'b1;
        step();
        chk("stall_stop_halted", 32'(halted), 32'd0);
        chk("stall_stop_pc", endereco_pc, 32'd5);
        stall = 1'b0;
        step();
        chk("stop_halted", 32'(halted), 32'd1);
        chk("stop_running", 32'(running), 32'd0);
        chk("stop_pc", endereco_pc, 32'd5);
        chk("stop_cnt", instr_count, 32'd14);
        step(); chk("halt_hold_pc", endereco_pc, 32'd5);

        instr_drv = add_w; start = 1'b1;
        step(); start = 1'b0;
        chk("restart_running", 32'(running), 32'd1);
        chk("restart_halted", 32'(halted), 32'd0);
        chk("restart_pc", endereco_pc, 32'd0);
        chk("restart_cnt", instr_count, 32'd0);
        repeat (4) step();
        chk("pre_ill_pc", endereco_pc, 32'd4);
        instr_drv = 32'hFC00_0000;
        step();
        chk("ill_fault", 32'(fault), 32'd1);
        chk("ill_running", 32'(running), 32'd0);
        chk("ill_pc", endereco_pc, 32'd4);
        chk("ill_cnt", instr_count, 32'd4);

        start = 1'b1;
        step(); start = 1'b0;
        chk("fault_restart_pc", endereco_pc, 32'd0);
        instr_drv = enc_j(T_J, 26'd300);
        step();
        chk("j300_fault", 32'(fault), 32'd1);
        chk("j300_pc", endereco_pc, 32'd0);

        instr_drv = enc(T_BEQ, 5'd0, 5'd0, 16'hFFFE); bc_drv = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        chk("wrap_running", 32'(running), 32'd1);
        step();
        chk("wrap_fault", 32'(fault), 32'd1);
        chk("wrap_pc", endereco_pc, 32'd0);

        instr_drv = add_w; bc_drv = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        chk("pre_rst_pc", endereco_pc, 32'd2);
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("midrst_pc", endereco_pc, 32'd0);
        chk("midrst_running", 32'(running), 32'd0);
        chk("midrst_cnt", instr_count, 32'd0);
        step();
        chk("idle_hold_running", 32'(running), 32'd0);

        use_mem = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        repeat (5) step();
        chk("fact_mid_pc", endereco_pc, 32'd5);
        stall = 1'b1;
        repeat (3) step();
        chk("fact_stall_pc", endereco_pc, 32'd5);
        chk("fact_stall_cnt", instr_count, 32'd5);
        stall = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (halted || fault) break;
            step();
        end
        chk("fact_halted", 32'(halted), 32'd1);
        chk("fact_pc", endereco_pc, 32'd7);
        chk("fact_cnt", instr_count, 32'd24);
        chk("fact_result", regs[2], 32'd720);

        start = 1'b1;
        step(); start = 1'b0;
        chk("rerun_pc", endereco_pc, 32'd0);
        chk("rerun_cnt", instr_count, 32'd0);
        chk("rerun_running", 32'(running), 32'd1);
        step();
        chk("rerun_pc1", endereco_pc, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
